// File: rtl/wordle_pkg.sv
// Shared score codes, FSM encoding and sizing helper for the Wordle guess scorer.
package wordle_pkg;
  localparam logic [1:0] SC_EMPTY  = 2'b00;
  localparam logic [1:0] SC_GRAY   = 2'b01;
  localparam logic [1:0] SC_YELLOW = 2'b10;
  localparam logic [1:0] SC_GREEN  = 2'b11;

  localparam logic [7:0] LETTER_BLANK = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_GREEN, ST_YELLOW, ST_COMMIT} state_e;

  // Never returns 0 so that single-entry ranges still get a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/wordle_guess_scorer_if.sv
// Guess handshake and result bundle between the game FSM and the scorer.
interface wordle_guess_scorer_if #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 8
);
  logic                         guess_valid;
  logic                         guess_ready;
  logic [WORD_LEN*LETTER_W-1:0] guess_word;
  logic                         result_valid;
  logic [2*WORD_LEN-1:0]        result_score;

  modport master (output guess_valid, guess_word,
                  input  guess_ready, result_valid, result_score);
  modport slave  (input  guess_valid, guess_word,
                  output guess_ready, result_valid, result_score);
endinterface

// File: rtl/wordle_letter_match.sv
// Finds the lowest unused target position holding a given letter.
module wordle_letter_match
  import wordle_pkg::*;
#(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 8,
  parameter int IW       = clog2(WORD_LEN)
) (
  input  logic [LETTER_W-1:0]               letter,
  input  logic [WORD_LEN-1:0][LETTER_W-1:0] target,
  input  logic [WORD_LEN-1:0]               used,
  output logic                              hit,
  output logic [IW-1:0]                     idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (!used[j] && target[j] == letter) begin
        hit = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/wordle_guess_scorer.sv
// Scores a guess letter-by-letter (green pass, then yellow pass), commits it to
// the history rows and exposes a registered read port for the tile renderer.
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 8,
  localparam int CW = clog2(MAX_GUESSES + 1),
  localparam int RW = clog2(MAX_GUESSES),
  localparam int IW = clog2(WORD_LEN)
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         new_game,
  input  logic [WORD_LEN*LETTER_W-1:0] target_word,
  wordle_guess_scorer_if.slave         gif,
  output logic [CW-1:0]                guess_count,
  output logic                         game_won,
  output logic                         game_lost,
  input  logic [RW-1:0]                rd_row,
  input  logic [IW-1:0]                rd_col,
  output logic [LETTER_W-1:0]          rd_letter,
  output logic [1:0]                   rd_score
);
  typedef logic [WORD_LEN-1:0][LETTER_W-1:0] word_t;
  typedef logic [WORD_LEN-1:0][1:0]          score_t;

  // Internally element i is letter i; on the ports letter 0 sits in the MSBs.
  function automatic word_t unpack_word(input logic [WORD_LEN*LETTER_W-1:0] w);
    word_t r;
    for (int i = 0; i < WORD_LEN; i++) r[i] = w[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
    return r;
  endfunction

  function automatic logic [2*WORD_LEN-1:0] pack_score(input score_t s);
    logic [2*WORD_LEN-1:0] r;
    for (int i = 0; i < WORD_LEN; i++) r[2*(WORD_LEN-1-i) +: 2] = s[i];
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  active_q, active_d, won_q, won_d, lost_q, lost_d;
  word_t                 target_q, target_d, guess_q, guess_d;
  score_t                score_q, score_d;
  logic [WORD_LEN-1:0]   used_q, used_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rv_q, rv_d;
  logic [2*WORD_LEN-1:0] rs_q, rs_d;
  logic [LETTER_W-1:0]   rd_letter_q, rd_letter_d;
  logic [1:0]            rd_score_q, rd_score_d;
  word_t                 hl_q [MAX_GUESSES];
  word_t                 hl_d [MAX_GUESSES];
  score_t                hs_q [MAX_GUESSES];
  score_t                hs_d [MAX_GUESSES];

  logic          hit, last;
  logic [IW-1:0] hit_idx;

  wordle_letter_match #(.WORD_LEN(WORD_LEN), .LETTER_W(LETTER_W), .IW(IW)) u_match (
    .letter (guess_q[idx_q]),
    .target (target_q),
    .used   (used_q),
    .hit    (hit),
    .idx    (hit_idx)
  );

  assign gif.guess_ready  = (state_q == ST_IDLE) && active_q && !won_q && !lost_q;
  assign gif.result_valid = rv_q;
  assign gif.result_score = rs_q;
  assign guess_count      = cnt_q;
  assign game_won         = won_q;
  assign game_lost        = lost_q;
  assign rd_letter        = rd_letter_q;
  assign rd_score         = rd_score_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    won_d    = won_q;
    lost_d   = lost_q;
    target_d = target_q;
    guess_d  = guess_q;
    score_d  = score_q;
    used_d   = used_q;
    cnt_d    = cnt_q;
    rv_d     = 1'b0;
    rs_d     = rs_q;
    hl_d     = hl_q;
    hs_d     = hs_q;
    last     = (idx_q == IW'(WORD_LEN - 1));
    // new_game wins over everything, including a guess mid-scoring.
    if (new_game) begin
      target_d = unpack_word(target_word);
      cnt_d    = '0;
      won_d    = 1'b0;
      lost_d   = 1'b0;
      active_d = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (gif.guess_valid && gif.guess_ready) begin
          guess_d = unpack_word(gif.guess_word);
          score_d = '0;
          used_d  = '0;
          idx_d   = '0;
          state_d = ST_GREEN;
        end
        ST_GREEN: begin
          if (guess_q[idx_q] == target_q[idx_q]) begin
            score_d[idx_q] = SC_GREEN;
            used_d[idx_q]  = 1'b1;
          end else begin
            score_d[idx_q] = SC_GRAY;
          end
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) state_d = ST_YELLOW;
        end
        ST_YELLOW: begin
          if (score_q[idx_q] != SC_GREEN && hit) begin
            score_d[idx_q]  = SC_YELLOW;
            used_d[hit_idx] = 1'b1;
          end
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          hl_d[cnt_q[RW-1:0]] = guess_q;
          hs_d[cnt_q[RW-1:0]] = score_q;
          cnt_d   = cnt_q + 1'b1;
          rs_d    = pack_score(score_q);
          rv_d    = 1'b1;
          state_d = ST_IDLE;
          if (&score_q) won_d = 1'b1;
          else if (int'(cnt_q) + 1 == MAX_GUESSES) lost_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Rows not yet committed (or out-of-range coordinates) render as blank tiles.
  always_comb begin
    rd_letter_d = LETTER_W'(LETTER_BLANK);
    rd_score_d  = SC_EMPTY;
    if (int'(rd_row) < int'(cnt_q) && int'(rd_row) < MAX_GUESSES && int'(rd_col) < WORD_LEN) begin
      rd_letter_d = hl_q[rd_row][rd_col];
      rd_score_d  = hs_q[rd_row][rd_col];
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      active_q    <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      target_q    <= '0;
      guess_q     <= '0;
      score_q     <= '0;
      used_q      <= '0;
      cnt_q       <= '0;
      rv_q        <= 1'b0;
      rs_q        <= '0;
      rd_letter_q <= '0;
      rd_score_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
      target_q    <= target_d;
      guess_q     <= guess_d;
      score_q     <= score_d;
      used_q      <= used_d;
      cnt_q       <= cnt_d;
      rv_q        <= rv_d;
      rs_q        <= rs_d;
      rd_letter_q <= rd_letter_d;
      rd_score_q  <= rd_score_d;
    end
  end

  always_ff @(posedge Clk) begin
    hl_q <= hl_d;
    hs_q <= hs_d;
  end
endmodule
